decode_seq_stage: RTL
=====================

Name: decode_seq_stage

Overview:
Parametrised decode stage for the pipelined ARM-subset core. It merges the field decoder with the ID/EX pipeline register and adds a micro-op sequencer for block transfers (LDM/STM). The sequencer expands one register-list instruction into one load/store micro-op per set bit, plus an optional base-writeback micro-op. It sits between the IF/ID register and the execute stage, and drives a decode stall back to fetch while a sequence is running.

Parameters:
NREGS, 16, architectural register count; also the width of the register-list field Instr[NREGS-1:0]
RAW, $clog2(NREGS), register index width
OFFW, RAW+3, byte-offset width; holds 4*NREGS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
InstrD  in  32  instruction in D; Op=Instr[27:26], Funct=Instr[25:20]
ValidD  in  1  InstrD holds a real instruction
StallE  in  1  hold the E register and the sequencer
FlushE  in  1  kill E contents; abort any running sequence
StallD  out  1  combinational; fetch/decode must hold InstrD
ValidE  out  1  E holds a live op
RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE, NoWriteE, IgRnE  out  1 each  registered controls
ALUControlE  out  3  registered ALU op
FlagWE  out  2  registered flag-write enables
ImmSrcE, RegSrcE  out  2 each  registered
RdE, RnE  out  RAW each  destination / base register
OffsetE  out  OFFW  micro-op byte offset or writeback immediate
UopE  out  1  E op was produced by the sequencer
IllegalE  out  1  undefined encoding (registered)

Behaviour:
- Reset (reset=0, async): every E output is 0; the sequencer goes to IDLE with list and count cleared; StallD=0.
- Update priority on each rising edge: FlushE, then StallE, then normal update.
  - FlushE: E becomes a bubble (all outputs 0) and the sequencer returns to IDLE.
  - StallE: the E register, state, remaining list and count all hold.
- Single ops have 1-cycle latency: InstrD is decoded in D and registered into E.
- Data processing, Op=00:
  - ALUControl: AND/TST=010, EOR/TEQ=110, SUB/CMP=001, ADD/CMN=000, ORR=011, MOV=000.
  - TST/TEQ/CMP/CMN set NoWrite=1. MOV sets IgRn=1.
  - FlagW[1]=S; FlagW[0]=S and (ALUControl is 000 or 001).
  - Any other cmd, or Op=11, gives IllegalE=1, ValidE=0 and no writes.
- Load/store, Op=01: same control encodings as the existing single-cycle decode.
- Branch, Op=10 with Funct[5]=1: BranchE=1.
- PCSE = (Rd==15 and RegW) or Branch.
- Block transfer, Op=10 with Funct[5]=0:
  - Field meanings: L=Funct[0], W=Funct[1], U=Funct[3], P=Funct[4], base Rn=Instr[19:16].
  - U=0 is Illegal.
  - Empty list: bubble (ValidE=0, IllegalE=0), no stall.
- Sequencer states: IDLE, XFER, WB.
- IDLE, accepting a block transfer:
  - Issue micro-op k=0 for the lowest set bit this cycle.
  - Latch the remaining list (that bit cleared) and the total count N = popcount(list).
  - Next state: XFER if bits remain; else WB if W=1; else IDLE.
- XFER, each unstalled cycle:
  - Issue the next lowest set bit and increment k.
  - When the list empties, go to WB if W=1, else IDLE.
- Transfer micro-op fields:
  - RdE = bit index, RnE = Rn, OffsetE = 4*(k+P).
  - Load (L=1): MemtoReg=1, RegW=1. Store (L=0): MemW=1.
  - ALUSrc=1, ALUControl=000, UopE=1.
  - PCSE=1 if a load targets R15.
- WB micro-op: ADD Rn,Rn,#4*N. Fields: RdE=RnE=Rn, OffsetE=4*N, RegW=1, ALUSrc=1, UopE=1. Next state IDLE.
- StallD = StallE, or (sequencer will not be IDLE next cycle). It is therefore low in the cycle the last micro-op issues, and InstrD advances the following cycle.
- In XFER and WB, InstrD and ValidD are ignored.
- ValidD=0 while IDLE produces a bubble.
- An offset of 4*NREGS must fit in OFFW bits without wrap.

Test Plan:
- ADDS R1,R2,R3 (Op=00, Funct=001001) -> next cycle: ValidE=1, ALUControlE=000, FlagWE=11, RegWE=1, StallD=0 throughout.
- CMP R4,#5 -> NoWriteE=1, FlagWE=11, ALUControlE=001. Op=11 encoding -> IllegalE=1, ValidE=0.
- LDMIA R0!,{R1,R3,R15} -> four E ops:
  - (Rd=1, Off=0), (Rd=3, Off=4), (Rd=15, Off=8, PCSE=1), WB (Rd=0, Off=12, RegWE=1).
  - StallD high for exactly 3 cycles.
- STMIB R2,{R5,R6} with StallE held 2 cycles between the two micro-ops -> the first op holds; then (Rd=6, Off=8, MemWE=1); no WB; StallD stays high during the stall.
- FlushE asserted during the second micro-op of a 4-register LDM -> next cycle ValidE=0, state IDLE, StallD=0.
- reset pulled low mid-sequence -> all outputs 0 immediately (async). After release, an empty-list LDM gives a bubble with no stall.

Source files
------------

// File: rtl/decode_seq_stage.sv
// Decode stage for the ARM-subset pipeline: field decode, ID/EX register and
// an LDM/STM micro-op sequencer that stalls fetch while a block transfer expands.
//
// state  | meaning
// S_IDLE | decoding InstrD; a block transfer issues its first micro-op here
// S_XFER | issuing one load/store micro-op per remaining list bit
// S_WB   | issuing the base-writeback ADD Rn,Rn,#4*N
module decode_seq_stage #(
    parameter int NREGS = 16,
    parameter int RAW   = $clog2(NREGS),
    parameter int OFFW  = RAW + 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic            StallD,
    output logic            ValidE,
    output logic            RegWE,
    output logic            MemWE,
    output logic            MemtoRegE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            PCSE,
    output logic            NoWriteE,
    output logic            IgRnE,
    output logic [2:0]      ALUControlE,
    output logic [1:0]      FlagWE,
    output logic [1:0]      ImmSrcE,
    output logic [1:0]      RegSrcE,
    output logic [RAW-1:0]  RdE,
    output logic [RAW-1:0]  RnE,
    output logic [OFFW-1:0] OffsetE,
    output logic            UopE,
    output logic            IllegalE
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} seq_t;

    typedef struct packed {
        logic            valid;
        logic            reg_w;
        logic            mem_w;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic            pcs;
        logic            no_write;
        logic            ig_rn;
        logic [2:0]      alu_ctl;
        logic [1:0]      flag_w;
        logic [1:0]      imm_src;
        logic [1:0]      reg_src;
        logic [RAW-1:0]  rd;
        logic [RAW-1:0]  rn;
        logic [OFFW-1:0] offset;
        logic            uop;
        logic            illegal;
    } ectl_t;

    localparam logic [RAW-1:0] PC_IDX = RAW'(NREGS - 1);

    function automatic logic [RAW-1:0] lowest(input logic [NREGS-1:0] v);
        lowest = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (v[i]) lowest = RAW'(i);
    endfunction

    function automatic logic [RAW:0] popcount(input logic [NREGS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NREGS; i++)
            popcount = popcount + (RAW+1)'(v[i]);
    endfunction

    function automatic logic [OFFW-1:0] byte_off(input logic [RAW:0] n);
        byte_off = OFFW'(n) << 2;
    endfunction

    function automatic ectl_t xfer_uop(input logic [RAW-1:0] idx, input logic [RAW-1:0] rn,
                                       input logic ld, input logic [OFFW-1:0] off);
        xfer_uop            = '0;
        xfer_uop.valid      = 1'b1;
        xfer_uop.uop        = 1'b1;
        xfer_uop.alu_src    = 1'b1;
        xfer_uop.rd         = idx;
        xfer_uop.rn         = rn;
        xfer_uop.offset     = off;
        xfer_uop.mem_to_reg = ld;
        xfer_uop.reg_w      = ld;
        xfer_uop.mem_w      = ~ld;
        xfer_uop.pcs        = ld & (idx == PC_IDX);
    endfunction

    ectl_t            e_q, e_d;
    seq_t             seq_q, seq_d;
    logic [NREGS-1:0] rem_q, rem_d, pick, rem_nx;
    logic [RAW:0]     cnt_q, cnt_d, k_q, k_d;
    logic [RAW-1:0]   rn_q, rn_d, lo;
    logic             l_q, l_d, w_q, w_d, p_q, p_d;
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [RAW-1:0]   rd_f, rn_f;
    logic [2:0]       alu;
    logic             nw, ig, legal;
    logic             unused_cond;

    assign op          = InstrD[27:26];
    assign funct       = InstrD[25:20];
    assign rn_f        = InstrD[16 +: RAW];
    assign rd_f        = InstrD[12 +: RAW];
    assign unused_cond = ^InstrD[31:28];

    // One lowest-bit picker serves both the first micro-op and the XFER ones.
    always_comb begin
        pick = (seq_q == S_XFER) ? rem_q : InstrD[NREGS-1:0];
        lo   = lowest(pick);
        rem_nx = pick;
        rem_nx[lo] = 1'b0;
    end

    always_comb begin
        e_d   = '0;
        seq_d = seq_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        rn_d  = rn_q;
        l_d   = l_q;
        w_d   = w_q;
        p_d   = p_q;
        alu   = 3'b000;
        nw    = 1'b0;
        ig    = 1'b0;
        legal = 1'b1;
        case (seq_q)
            S_IDLE: if (ValidD) begin
                case (op)
                    2'b00: begin
                        case (funct[4:1])
                            4'b0000: alu = 3'b010;
                            4'b0001: alu = 3'b110;
                            4'b0010: alu = 3'b001;
                            4'b0100: alu = 3'b000;
                            4'b1000: begin alu = 3'b010; nw = 1'b1; end
                            4'b1001: begin alu = 3'b110; nw = 1'b1; end
                            4'b1010: begin alu = 3'b001; nw = 1'b1; end
                            4'b1011: begin alu = 3'b000; nw = 1'b1; end
                            4'b1100: alu = 3'b011;
                            4'b1101: begin alu = 3'b000; ig = 1'b1; end
                            default: legal = 1'b0;
                        endcase
                        if (legal) begin
                            e_d.valid    = 1'b1;
                            e_d.reg_w    = ~nw;
                            e_d.alu_src  = funct[5];
                            e_d.alu_ctl  = alu;
                            e_d.no_write = nw;
                            e_d.ig_rn    = ig;
                            e_d.flag_w   = {funct[0], funct[0] & (alu[2:1] == 2'b00)};
                            e_d.rd       = rd_f;
                            e_d.rn       = rn_f;
                            e_d.pcs      = ~nw & (rd_f == PC_IDX);
                        end else begin
                            e_d.illegal  = 1'b1;
                        end
                    end
                    2'b01: begin
                        e_d.valid      = 1'b1;
                        e_d.alu_src    = 1'b1;
                        e_d.imm_src    = 2'b01;
                        e_d.reg_src    = funct[0] ? 2'b00 : 2'b10;
                        e_d.mem_w      = ~funct[0];
                        e_d.mem_to_reg = funct[0];
                        e_d.reg_w      = funct[0];
                        e_d.rd         = rd_f;
                        e_d.rn         = rn_f;
                        e_d.pcs        = funct[0] & (rd_f == PC_IDX);
                    end
                    2'b10: begin
                        if (funct[5]) begin
                            e_d.valid   = 1'b1;
                            e_d.branch  = 1'b1;
                            e_d.alu_src = 1'b1;
                            e_d.imm_src = 2'b10;
                            e_d.reg_src = 2'b01;
                            e_d.pcs     = 1'b1;
                        end else if (!funct[3]) begin
                            e_d.illegal = 1'b1;
                        end else if (InstrD[NREGS-1:0] != '0) begin
                            e_d   = xfer_uop(lo, rn_f, funct[0], byte_off((RAW+1)'(funct[4])));
                            rem_d = rem_nx;
                            cnt_d = popcount(InstrD[NREGS-1:0]);
                            k_d   = (RAW+1)'(1);
                            rn_d  = rn_f;
                            l_d   = funct[0];
                            w_d   = funct[1];
                            p_d   = funct[4];
                            seq_d = (rem_nx != '0) ? S_XFER : (funct[1] ? S_WB : S_IDLE);
                        end
                    end
                    default: e_d.illegal = 1'b1;
                endcase
            end
            S_XFER: begin
                e_d   = xfer_uop(lo, rn_q, l_q, byte_off(k_q + (RAW+1)'(p_q)));
                rem_d = rem_nx;
                k_d   = k_q + (RAW+1)'(1);
                seq_d = (rem_nx != '0) ? S_XFER : (w_q ? S_WB : S_IDLE);
            end
            S_WB: begin
                e_d.valid   = 1'b1;
                e_d.uop     = 1'b1;
                e_d.reg_w   = 1'b1;
                e_d.alu_src = 1'b1;
                e_d.rd      = rn_q;
                e_d.rn      = rn_q;
                e_d.offset  = byte_off(cnt_q);
                e_d.pcs     = (rn_q == PC_IDX);
                seq_d       = S_IDLE;
            end
            default: seq_d = S_IDLE;
        endcase
    end

    // Held low in reset so fetch is never frozen while the core is held.
    assign StallD = reset & (StallE | (~FlushE & (seq_d != S_IDLE)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q   <= '0;
            seq_q <= S_IDLE;
            rem_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
            rn_q  <= '0;
            l_q   <= 1'b0;
            w_q   <= 1'b0;
            p_q   <= 1'b0;
        end else if (FlushE) begin
            e_q   <= '0;
            seq_q <= S_IDLE;
            rem_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else if (!StallE) begin
            e_q   <= e_d;
            seq_q <= seq_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
            rn_q  <= rn_d;
            l_q   <= l_d;
            w_q   <= w_d;
            p_q   <= p_d;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWE       = e_q.reg_w;
    assign MemWE       = e_q.mem_w;
    assign MemtoRegE   = e_q.mem_to_reg;
    assign ALUSrcE     = e_q.alu_src;
    assign BranchE     = e_q.branch;
    assign PCSE        = e_q.pcs;
    assign NoWriteE    = e_q.no_write;
    assign IgRnE       = e_q.ig_rn;
    assign ALUControlE = e_q.alu_ctl;
    assign FlagWE      = e_q.flag_w;
    assign ImmSrcE     = e_q.imm_src;
    assign RegSrcE     = e_q.reg_src;
    assign RdE         = e_q.rd;
    assign RnE         = e_q.rn;
    assign OffsetE     = e_q.offset;
    assign UopE        = e_q.uop;
    assign IllegalE    = e_q.illegal;

endmodule
